link_sync_ctrl: RTL and testbench
=================================

# link_sync_ctrl

Word-alignment and link-synchronisation controller for the 8b/10b receive path. It sits directly after the deserializer/decoder, watches each decoded word together with its code/disparity error flags, and issues single-cycle bit-slip pulses until the configured comma is found at the word boundary. It then verifies lock, gates valid payload downstream, and drops back to hunting after repeated errors. It is the only block that sequences the deserializer's word boundary.

## Interface

Parameters:
- `COMMA`, 9'h13C: comma to hunt for, as {K flag, 8-bit value}; default K28.1.
- `HUNT_WORDS`, 16: words examined without a comma before a bit-slip is issued (≥2).
- `VERIFY_COMMAS`, 3: commas required in VERIFY before declaring lock (≥1).
- `BAD_MAX`, 4: accumulated bad-word count in LOCKED that forces loss of sync.
- `GOOD_CLEAR`, 4: consecutive good words in LOCKED that decrement the bad count by one.
- `SLIP_GUARD`, 2: word strobes ignored after each bit-slip (deserializer flush).

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `word_stb_i` in 1: one-cycle strobe per decoded word; data and flags are valid in the same cycle. Integration derives it from the deserializer's end-of-block flag delayed one cycle.
- `word_i` in 9: decoded word, bit 8 = K flag.
- `code_err_i` in 1: decoder code error for this word.
- `disp_err_i` in 1: decoder disparity error for this word.
- `err_clr_i` in 1: synchronous clear of `err_cnt_o`.
- `bitslip_o` out 1: one-cycle pulse; the deserializer shifts its boundary by one bit.
- `sync_o` out 1: high while in LOCKED.
- `rx_data_o` out 8: payload byte.
- `rx_k_o` out 1: payload K flag.
- `rx_valid_o` out 1: payload qualifier.
- `state_o` out 2: HUNT=0, VERIFY=1, LOCKED=2.
- `err_cnt_o` out 16: saturating count of bad words seen while LOCKED.

## Operation

- Bad word: `code_err_i` | `disp_err_i`. Comma: not bad and `word_i == COMMA`.
- Guard: after a bit-slip, the next `SLIP_GUARD` strobes are ignored entirely. No counters change and no state transitions occur.
- HUNT: each counted strobe increments `word_cnt`.
  - Comma → VERIFY, `comma_cnt` = 1, `word_cnt` = 0.
  - Else, when `word_cnt` reaches `HUNT_WORDS`-1 → pulse `bitslip_o`, set `word_cnt` = 0, load guard.
- VERIFY:
  - Bad word → HUNT, counters cleared, no slip.
  - Comma → `comma_cnt`++. On reaching `VERIFY_COMMAS` → LOCKED, with `bad_cnt` and `good_run` cleared.
  - Valid non-comma word → `word_cnt`++. At `HUNT_WORDS`-1 without completing verification → HUNT plus a bit-slip.
- LOCKED:
  - Every strobe → `rx_valid_o` pulse carrying the word.
  - Bad word → `bad_cnt`++, `good_run` = 0, `err_cnt_o`++ (saturating at 16'hFFFF). If `bad_cnt` reaches `BAD_MAX` → HUNT.
  - Good word → `good_run`++. At `GOOD_CLEAR` with `bad_cnt` > 0 → `bad_cnt`--, `good_run` = 0.
- `err_clr_i` and an increment in the same cycle: the clear wins and the result is 0.
- Counters never wrap; all comparisons use equality on terminal values.

## Timing

- Reset values: state HUNT, all counters 0, guard 0, every output 0.
- Reset takes effect immediately at any point, including mid-slip or mid-lock. The first post-reset word is counted (no guard).
- Outputs are registered and update on the edge after `word_stb_i`. Latency is one cycle from strobe to `rx_valid_o`, `bitslip_o`, `sync_o` and `state_o`.
- `bitslip_o` is never high in two consecutive cycles. It never asserts during the guard or in LOCKED.
- On the transition into LOCKED, the completing comma word is itself emitted with `rx_valid_o`.
- On the LOCKED→HUNT word, the bad word is still emitted with `rx_valid_o`, and `sync_o` falls in the same cycle.
- Without `word_stb_i`, nothing changes except `err_clr_i`.

## Structure

- Package `link_sync_pkg`:
  - `sync_state_e` enum (2-bit).
  - Default `COMMA` constants for K28.1 and K28.5.
  - An `is_bad` helper function.
- Sub-module `sat_counter` (parameterised width, increment, clear, saturate) is used for `err_cnt_o`. All other logic lives in a single FSM module.

## Test plan

- Reset with the comma present at a 3-bit offset → exactly 3 slips, each followed by 2 ignored strobes. Then VERIFY, then LOCKED after the 3rd comma; `sync_o`=1 and `state_o`=2.
- Aligned stream with no commas → `bitslip_o` pulses every 16 counted words plus 2 guard words, i.e. every 18 strobes. State stays 0.
- LOCKED, then 4 bad words separated by 2 good words each → `err_cnt_o`=4 and the block drops to HUNT on the 4th. With 4 good words between bad words, lock holds indefinitely.
- VERIFY after 1 comma, then one `disp_err_i` → HUNT, no slip, `rx_valid_o` never asserted.
- `err_cnt_o` preset near 16'hFFFF via sustained errors with `BAD_MAX` overridden large → saturates at FFFF. `err_clr_i` coincident with a bad word → 0.
- `rst_ni` low mid-LOCKED → all outputs 0 asynchronously. Relock from the same aligned stream requires 3 commas.

Source files
------------

// File: rtl/link_sync_pkg.sv
// Shared types and constants for the 8b/10b word-alignment controller.
// Imported by the FSM top level.
package link_sync_pkg;

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StVerify = 2'd1,
        StLocked = 2'd2
    } sync_state_e;

    // Commas as {K flag, 8-bit value}.
    localparam logic [8:0] COMMA_K28_1 = 9'h13C;
    localparam logic [8:0] COMMA_K28_5 = 9'h1BC;

    function automatic logic is_bad(input logic code_err, input logic disp_err);
        return code_err | disp_err;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a clear has priority over an increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/link_sync_ctrl.sv
// Word-alignment / link-sync FSM: hunts for the comma with bit-slips, verifies lock,
// gates payload while locked and falls back to hunting on accumulated errors.
module link_sync_ctrl
    import link_sync_pkg::*;
#(
    parameter logic [8:0]  COMMA         = COMMA_K28_1,
    parameter int unsigned HUNT_WORDS    = 16,
    parameter int unsigned VERIFY_COMMAS = 3,
    parameter int unsigned BAD_MAX       = 4,
    parameter int unsigned GOOD_CLEAR    = 4,
    parameter int unsigned SLIP_GUARD    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        word_stb_i,
    input  logic [8:0]  word_i,
    input  logic        code_err_i,
    input  logic        disp_err_i,
    input  logic        err_clr_i,
    output logic        bitslip_o,
    output logic        sync_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_k_o,
    output logic        rx_valid_o,
    output logic [1:0]  state_o,
    output logic [15:0] err_cnt_o
);

    localparam int unsigned WcW = (HUNT_WORDS > 1) ? $clog2(HUNT_WORDS) : 1;
    localparam int unsigned CcW = $clog2(VERIFY_COMMAS + 1);
    localparam int unsigned BcW = $clog2(BAD_MAX + 1);
    localparam int unsigned GrW = $clog2(GOOD_CLEAR + 1);
    localparam int unsigned GdW = (SLIP_GUARD > 0) ? $clog2(SLIP_GUARD + 1) : 1;

    localparam logic [WcW-1:0] WordLast  = WcW'(HUNT_WORDS - 1);
    localparam logic [CcW-1:0] CommaLast = CcW'(VERIFY_COMMAS - 1);
    localparam logic [BcW-1:0] BadLast   = BcW'(BAD_MAX - 1);
    localparam logic [GrW-1:0] GoodLast  = GrW'(GOOD_CLEAR - 1);
    localparam logic [GrW-1:0] GoodFull  = GrW'(GOOD_CLEAR);
    localparam logic [GdW-1:0] GuardLoad = GdW'(SLIP_GUARD);

    sync_state_e    state, state_next;
    logic [WcW-1:0] word_cnt, word_cnt_next;
    logic [CcW-1:0] comma_cnt, comma_cnt_next;
    logic [BcW-1:0] bad_cnt, bad_cnt_next;
    logic [GrW-1:0] good_run, good_run_next;
    logic [GdW-1:0] guard, guard_next;
    logic           slip_next, valid_next, k_next, err_inc;
    logic [7:0]     data_next;
    logic           bad, comma;

    assign bad   = is_bad(code_err_i, disp_err_i);
    assign comma = !bad && (word_i == COMMA);

    always_comb begin
        state_next     = state;
        word_cnt_next  = word_cnt;
        comma_cnt_next = comma_cnt;
        bad_cnt_next   = bad_cnt;
        good_run_next  = good_run;
        guard_next     = guard;
        slip_next      = 1'b0;
        valid_next     = 1'b0;
        data_next      = rx_data_o;
        k_next         = rx_k_o;
        err_inc        = 1'b0;

        if (word_stb_i) begin
            // Strobes inside the post-slip guard window carry stale deserializer data.
            if (guard != '0) begin
                guard_next = guard - 1'b1;
            end else begin
                unique case (state)
                    StHunt: begin
                        if (comma) begin
                            word_cnt_next = '0;
                            if (VERIFY_COMMAS == 1) begin
                                state_next    = StLocked;
                                bad_cnt_next  = '0;
                                good_run_next = '0;
                                valid_next    = 1'b1;
                                data_next     = word_i[7:0];
                                k_next        = word_i[8];
                            end else begin
                                state_next     = StVerify;
                                comma_cnt_next = CcW'(1);
                            end
                        end else if (word_cnt == WordLast) begin
                            slip_next     = 1'b1;
                            word_cnt_next = '0;
                            guard_next    = GuardLoad;
                        end else begin
                            word_cnt_next = word_cnt + 1'b1;
                        end
                    end
                    StVerify: begin
                        if (bad) begin
                            state_next     = StHunt;
                            word_cnt_next  = '0;
                            comma_cnt_next = '0;
                        end else if (comma) begin
                            if (comma_cnt == CommaLast) begin
                                state_next     = StLocked;
                                word_cnt_next  = '0;
                                comma_cnt_next = '0;
                                bad_cnt_next   = '0;
                                good_run_next  = '0;
                                valid_next     = 1'b1;
                                data_next      = word_i[7:0];
                                k_next         = word_i[8];
                            end else begin
                                comma_cnt_next = comma_cnt + 1'b1;
                            end
                        end else if (word_cnt == WordLast) begin
                            state_next     = StHunt;
                            slip_next      = 1'b1;
                            word_cnt_next  = '0;
                            comma_cnt_next = '0;
                            guard_next     = GuardLoad;
                        end else begin
                            word_cnt_next = word_cnt + 1'b1;
                        end
                    end
                    StLocked: begin
                        valid_next = 1'b1;
                        data_next  = word_i[7:0];
                        k_next     = word_i[8];
                        if (bad) begin
                            err_inc       = 1'b1;
                            good_run_next = '0;
                            if (bad_cnt == BadLast) begin
                                state_next   = StHunt;
                                bad_cnt_next = '0;
                            end else begin
                                bad_cnt_next = bad_cnt + 1'b1;
                            end
                        end else if (good_run != GoodFull) begin
                            // good_run parks at GoodFull while there is nothing to forgive.
                            if ((good_run == GoodLast) && (bad_cnt != '0)) begin
                                bad_cnt_next  = bad_cnt - 1'b1;
                                good_run_next = '0;
                            end else begin
                                good_run_next = good_run + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_next = StHunt;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= StHunt;
            word_cnt   <= '0;
            comma_cnt  <= '0;
            bad_cnt    <= '0;
            good_run   <= '0;
            guard      <= '0;
            bitslip_o  <= 1'b0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
            rx_k_o     <= 1'b0;
        end else begin
            state      <= state_next;
            word_cnt   <= word_cnt_next;
            comma_cnt  <= comma_cnt_next;
            bad_cnt    <= bad_cnt_next;
            good_run   <= good_run_next;
            guard      <= guard_next;
            bitslip_o  <= slip_next;
            rx_valid_o <= valid_next;
            rx_data_o  <= data_next;
            rx_k_o     <= k_next;
        end
    end

    assign sync_o  = (state == StLocked);
    assign state_o = state;

    sat_counter #(
        .WIDTH (16)
    ) u_err_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (err_inc),
        .clr    (err_clr_i),
        .count  (err_cnt_o)
    );

endmodule

// File: tb/tb_link_sync_ctrl.sv
// Randomised bench for link_sync_ctrl: a word-level reference model scores every strobe,
// and scenario tasks check alignment, loss of sync, reset and error-count saturation.
module tb_link_sync_ctrl;

    localparam logic [8:0] COMMA      = 9'h13C;
    localparam int         HUNT_WORDS = 16;
    localparam int         VERIFY_N   = 3;
    localparam int         BAD_MAX    = 4;
    localparam int         GOOD_CLEAR = 4;
    localparam int         SLIP_GUARD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, code = 1'b0, disp = 1'b0, clr = 1'b0;
    logic [8:0]  word = '0;
    logic        slip, sync, rk, rvalid;
    logic [7:0]  rdata;
    logic [1:0]  st;
    logic [15:0] ecnt;

    logic        stb2 = 1'b0, code2 = 1'b0, clr2 = 1'b0;
    logic [8:0]  word2 = '0;
    logic        slip2, sync2, rk2, rvalid2;
    logic [7:0]  rdata2;
    logic [1:0]  st2;
    logic [15:0] ecnt2;

    always #5 clk = ~clk;

    link_sync_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .word_stb_i(stb), .word_i(word), .code_err_i(code),
        .disp_err_i(disp), .err_clr_i(clr), .bitslip_o(slip), .sync_o(sync),
        .rx_data_o(rdata), .rx_k_o(rk), .rx_valid_o(rvalid), .state_o(st), .err_cnt_o(ecnt)
    );

    link_sync_ctrl #(
        .BAD_MAX (70000)
    ) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .word_stb_i(stb2), .word_i(word2), .code_err_i(code2),
        .disp_err_i(1'b0), .err_clr_i(clr2), .bitslip_o(slip2), .sync_o(sync2),
        .rx_data_o(rdata2), .rx_k_o(rk2), .rx_valid_o(rvalid2), .state_o(st2),
        .err_cnt_o(ecnt2)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: 0 hunting, 1 verifying, 2 locked.
    int m_mode, m_wc, m_cc, m_bad, m_good, m_guard, m_err;
    bit e_slip, e_valid;
    logic [8:0] e_word;

    // Physical stream: comma every 4th word once the boundary offset reaches zero.
    int offset = 0;
    int phase = 0;
    bit no_commas = 0;
    int slips_seen = 0;
    int strobe_idx = 0;
    int slip_at[$];

    task automatic model_reset();
        m_mode = 0; m_wc = 0; m_cc = 0; m_bad = 0; m_good = 0; m_guard = 0; m_err = 0;
        e_slip = 0; e_valid = 0; e_word = '0;
    endtask

    task automatic model_step(input logic [8:0] w, input logic ce, input logic de,
                              input logic cl);
        bit is_bad, is_comma, inc;
        is_bad = ce | de;
        is_comma = !is_bad && (w == COMMA);
        inc = 0;
        e_slip = 0;
        e_valid = 0;
        if (m_guard > 0) begin
            m_guard--;
        end else if (m_mode == 0) begin
            if (is_comma) begin
                m_mode = 1; m_cc = 1; m_wc = 0;
            end else if (m_wc == HUNT_WORDS - 1) begin
                e_slip = 1; m_wc = 0; m_guard = SLIP_GUARD;
            end else begin
                m_wc++;
            end
        end else if (m_mode == 1) begin
            if (is_bad) begin
                m_mode = 0; m_wc = 0; m_cc = 0;
            end else if (is_comma) begin
                m_cc++;
                if (m_cc == VERIFY_N) begin
                    m_mode = 2; m_wc = 0; m_cc = 0; m_bad = 0; m_good = 0;
                    e_valid = 1; e_word = w;
                end
            end else if (m_wc == HUNT_WORDS - 1) begin
                m_mode = 0; e_slip = 1; m_wc = 0; m_cc = 0; m_guard = SLIP_GUARD;
            end else begin
                m_wc++;
            end
        end else begin
            e_valid = 1; e_word = w;
            if (is_bad) begin
                inc = 1; m_bad++; m_good = 0;
                if (m_bad == BAD_MAX) begin
                    m_mode = 0; m_bad = 0; m_wc = 0; m_cc = 0;
                end
            end else begin
                m_good = (m_good + 1 > GOOD_CLEAR) ? GOOD_CLEAR : m_good + 1;
                if (m_good == GOOD_CLEAR && m_bad > 0) begin
                    m_bad--; m_good = 0;
                end
            end
        end
        if (cl) m_err = 0;
        else if (inc && m_err < 65535) m_err++;
    endtask

    task automatic next_stream_word(output logic [8:0] w);
        if (!no_commas && offset == 0 && (phase % 4) == 0) begin
            w = COMMA;
        end else begin
            w = {1'b0, 8'($urandom)};
            if ($urandom_range(0, 7) == 0) w = 9'h1BC;
        end
        phase++;
    endtask

    // Called at a negedge; strobes one word, scores it, then idles for gap cycles.
    task automatic drive_word(input logic [8:0] w, input logic ce, input logic de,
                              input logic cl, input int gap);
        word = w; code = ce; disp = de; clr = cl; stb = 1'b1;
        model_step(w, ce, de, cl);
        @(negedge clk);
        stb = 1'b0; code = 1'b0; disp = 1'b0; clr = 1'b0;
        strobe_idx++;
        vectors += 5;
        if (slip !== e_slip) begin
            miscompares++;
            $display("FAIL bitslip strobe %0d: got %b expected %b", strobe_idx, slip, e_slip);
        end
        if (rvalid !== e_valid) begin
            miscompares++;
            $display("FAIL rx_valid strobe %0d: got %b expected %b", strobe_idx, rvalid, e_valid);
        end
        if (st !== 2'(m_mode)) begin
            miscompares++;
            $display("FAIL state strobe %0d: got %0d expected %0d", strobe_idx, st, m_mode);
        end
        if (sync !== (m_mode == 2)) begin
            miscompares++;
            $display("FAIL sync strobe %0d: got %b expected %b", strobe_idx, sync, m_mode == 2);
        end
        if (ecnt !== 16'(m_err)) begin
            miscompares++;
            $display("FAIL err_cnt strobe %0d: got %0d expected %0d", strobe_idx, ecnt, m_err);
        end
        if (e_valid) begin
            vectors++;
            if ({rk, rdata} !== e_word) begin
                miscompares++;
                $display("FAIL rx_word strobe %0d: got %h expected %h", strobe_idx,
                         {rk, rdata}, e_word);
            end
        end
        if (slip === 1'b1) begin
            slips_seen++;
            slip_at.push_back(strobe_idx);
            offset = (offset + 9) % 10;
        end
        repeat (gap) begin
            @(negedge clk);
            vectors++;
            if (slip !== 1'b0 || rvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL idle pulses: got slip=%b valid=%b expected 0", slip, rvalid);
            end
        end
    endtask

    task automatic stream_word(input int err_pct, input int clr_pct, input int max_gap);
        logic [8:0] w;
        logic ce, de;
        next_stream_word(w);
        ce = ($urandom_range(0, 99) < err_pct);
        de = ($urandom_range(0, 99) < err_pct);
        drive_word(w, ce, de, $urandom_range(0, 99) < clr_pct, $urandom_range(0, max_gap));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        strobe_idx = 0; slips_seen = 0; phase = 0;
        slip_at.delete();
    endtask

    task automatic lock_aligned();
        int n = 0;
        offset = 0;
        while (m_mode != 2 && n < 60) begin
            stream_word(0, 0, 1);
            n++;
        end
        vectors++;
        if (m_mode != 2 || sync !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_aligned: got sync=%b expected 1 within 60 words", sync);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({slip, sync, rdata, rk, rvalid, st, ecnt} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: got %h expected 0",
                     {slip, sync, rdata, rk, rvalid, st, ecnt});
        end
        do_reset();
    endtask

    task automatic test_offset_lock();
        int n = 0;
        do_reset();
        offset = 3;
        while (m_mode != 2 && n < 300) begin
            stream_word(0, 0, 1);
            n++;
        end
        vectors += 3;
        if (slips_seen != 3) begin
            miscompares++;
            $display("FAIL offset_slips: got %0d expected 3", slips_seen);
        end
        if (st !== 2'd2 || sync !== 1'b1) begin
            miscompares++;
            $display("FAIL offset_lock: got state=%0d sync=%b expected 2/1", st, sync);
        end
        if (n >= 300) begin
            miscompares++;
            $display("FAIL offset_budget: got %0d words expected lock earlier", n);
        end
    endtask

    task automatic test_no_comma();
        do_reset();
        no_commas = 1;
        for (int i = 0; i < 60; i++) stream_word(0, 0, 0);
        no_commas = 0;
        vectors += 2;
        if (slip_at.size() != 3) begin
            miscompares++;
            $display("FAIL no_comma_slips: got %0d expected 3", slip_at.size());
        end else if (slip_at[0] != 16 || slip_at[1] != 34 || slip_at[2] != 52) begin
            miscompares++;
            $display("FAIL no_comma_period: got %0d,%0d,%0d expected 16,34,52",
                     slip_at[0], slip_at[1], slip_at[2]);
        end
        if (st !== 2'd0) begin
            miscompares++;
            $display("FAIL no_comma_state: got %0d expected 0", st);
        end
    endtask

    task automatic test_lock_loss();
        do_reset();
        lock_aligned();
        for (int k = 0; k < 4; k++) begin
            drive_word({1'b0, 8'($urandom)}, 1'b1, 1'b0, 1'b0, 0);
            if (k < 3) repeat (2) stream_word(0, 0, 0);
        end
        vectors += 2;
        if (ecnt !== 16'd4) begin
            miscompares++;
            $display("FAIL lock_loss_errs: got %0d expected 4", ecnt);
        end
        if (st !== 2'd0 || sync !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_loss_state: got %0d expected 0", st);
        end
        lock_aligned();
        for (int k = 0; k < 8; k++) begin
            drive_word({1'b0, 8'($urandom)}, 1'b0, 1'b1, 1'b0, 1);
            repeat (4) stream_word(0, 0, 0);
        end
        vectors += 2;
        if (st !== 2'd2) begin
            miscompares++;
            $display("FAIL lock_hold_state: got %0d expected 2", st);
        end
        if (ecnt !== 16'd12) begin
            miscompares++;
            $display("FAIL lock_hold_errs: got %0d expected 12", ecnt);
        end
    endtask

    task automatic test_verify_abort();
        do_reset();
        drive_word(COMMA, 1'b0, 1'b0, 1'b0, 0);
        drive_word({1'b0, 8'h4A}, 1'b0, 1'b1, 1'b0, 2);
        vectors++;
        if (st !== 2'd0 || slips_seen != 0) begin
            miscompares++;
            $display("FAIL verify_abort: got state=%0d slips=%0d expected 0/0", st, slips_seen);
        end
    endtask

    task automatic test_random();
        do_reset();
        offset = $urandom_range(0, 9);
        for (int i = 0; i < 600; i++) stream_word(4, 5, 2);
    endtask

    task automatic test_async_reset();
        do_reset();
        lock_aligned();
        drive_word({1'b0, 8'h11}, 1'b1, 1'b0, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({slip, sync, rdata, rk, rvalid, st, ecnt} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected 0",
                     {slip, sync, rdata, rk, rvalid, st, ecnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive_word(COMMA, 1'b0, 1'b0, 1'b0, 0);
        drive_word({1'b0, 8'h22}, 1'b0, 1'b0, 1'b0, 0);
        drive_word(COMMA, 1'b0, 1'b0, 1'b0, 0);
        vectors++;
        if (st !== 2'd1 || sync !== 1'b0) begin
            miscompares++;
            $display("FAIL relock_early: got state=%0d expected 1", st);
        end
        drive_word(COMMA, 1'b0, 1'b0, 1'b0, 0);
        vectors++;
        if (st !== 2'd2 || sync !== 1'b1) begin
            miscompares++;
            $display("FAIL relock_third: got state=%0d expected 2", st);
        end
    endtask

    task automatic test_saturation();
        int n = 0;
        do_reset();
        stb2 = 1'b1; word2 = COMMA; code2 = 1'b0;
        repeat (3) @(negedge clk);
        word2 = 9'h055; code2 = 1'b1;
        repeat (65534) @(negedge clk);
        n = 65534;
        vectors++;
        if (ecnt2 !== 16'(n)) begin
            miscompares++;
            $display("FAIL sat_near: got %h expected %h", ecnt2, 16'(n));
        end
        @(negedge clk);
        vectors++;
        if (ecnt2 !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_top: got %h expected ffff", ecnt2);
        end
        repeat (3) @(negedge clk);
        vectors += 2;
        if (ecnt2 !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_hold: got %h expected ffff", ecnt2);
        end
        if (st2 !== 2'd2) begin
            miscompares++;
            $display("FAIL sat_state: got %0d expected 2", st2);
        end
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        vectors++;
        if (ecnt2 !== 16'd0) begin
            miscompares++;
            $display("FAIL sat_clr_wins: got %h expected 0", ecnt2);
        end
        @(negedge clk);
        stb2 = 1'b0; code2 = 1'b0;
        vectors++;
        if (ecnt2 !== 16'd1) begin
            miscompares++;
            $display("FAIL sat_after_clr: got %h expected 1", ecnt2);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_offset_lock();
        test_no_comma();
        test_lock_loss();
        test_verify_abort();
        test_random();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
